fxp2fp_norm_pack: RTL and testbench



---
 rtl/fxp2fp_norm_pack.sv | 148 ++++++++++++++
 tb/tb_fxp2fp_norm_pack.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp2fp_norm_pack.sv
`default_nettype none
// ============================================================================
// Module   : fxp2fp_norm_pack
// Purpose  : Normalise / round / pack stage of the signed-fraction to float32
//            converter. Takes sign, 32-bit magnitude (value = mag / 2^31) and
//            leading-zero count from the abs + LZD tree, and emits an
//            IEEE-754 single-precision word through a two-deep registered
//            pipeline with valid/ready handshakes on both sides.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid / in_ready   - upstream handshake
//            in_sign, in_mag,
//            in_lzd, in_zero       - sign, magnitude, leading zeros, mag==0
//            out_valid / out_ready - downstream handshake
//            out_data              - float32 result
//            out_exact             - 1 = no nonzero bits discarded
// Config   : FP_ROUND_RNE_EN defined   -> round-to-nearest-even
//            FP_ROUND_RNE_EN undefined -> truncation
// Revision : 1.0 - initial release
// ============================================================================
module fxp2fp_norm_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [31:0] in_mag,
  input  logic [5:0]  in_lzd,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_exact
);

  // S1 registers
  logic        s1_valid_q, s1_valid_d;
  logic        sign1_q,    sign1_d;
  logic        zero1_q,    zero1_d;
  logic [7:0]  exp1_q,     exp1_d;
  logic [31:0] norm1_q,    norm1_d;

  // S2 (output) registers
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_exact_q, out_exact_d;

  // Handshake
  logic w_s2_load;
  logic w_s1_load;
  logic w_accept;

  // S2 datapath
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_up;
  logic [23:0] w_mant_sum;
  logic [7:0]  w_exp_r;
  logic [31:0] w_result;
  logic        w_exact;

  always_comb begin
    w_s2_load = ~out_valid_q | out_ready;
    w_s1_load = ~s1_valid_q | w_s2_load;
    w_accept  = in_valid & w_s1_load;
  end

  always_comb begin
    w_mant   = norm1_q[30:8];
    w_guard  = norm1_q[7];
    w_sticky = |norm1_q[6:0];
`ifdef FP_ROUND_RNE_EN
    w_up     = w_guard & (w_sticky | w_mant[0]);
`else
    w_up     = 1'b0;
`endif
    w_mant_sum = {1'b0, w_mant} + {23'd0, w_up};
    // A carry out of the mantissa leaves sum[22:0] == 0, which is exactly the
    // mantissa of the next binade, so only the exponent needs bumping.
    w_exp_r = w_mant_sum[23] ? (exp1_q + 8'd1) : exp1_q;
    if (zero1_q) begin
      w_result = 32'h0000_0000;
      w_exact  = 1'b1;
    end else begin
      w_result = {sign1_q, w_exp_r, w_mant_sum[22:0]};
      w_exact  = ~(w_guard | w_sticky);
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    sign1_d     = sign1_q;
    zero1_d     = zero1_q;
    exp1_d      = exp1_q;
    norm1_d     = norm1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_exact_d = out_exact_q;

    if (w_s1_load) begin
      s1_valid_d = in_valid;
    end
    if (w_accept) begin
      sign1_d = in_sign;
      zero1_d = in_zero;
      // For a zero beat the lzd value is meaningless; S2 overrides the result.
      exp1_d  = 8'd127 - {2'b00, in_lzd};
      norm1_d = in_mag << in_lzd;
    end

    if (w_s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = w_result;
        out_exact_d = w_exact;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      sign1_q     <= 1'b0;
      zero1_q     <= 1'b0;
      exp1_q      <= 8'd0;
      norm1_q     <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_exact_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sign1_q     <= sign1_d;
      zero1_q     <= zero1_d;
      exp1_q      <= exp1_d;
      norm1_q     <= norm1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_exact_q <= out_exact_d;
    end
  end

  assign in_ready  = w_s1_load;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_exact = out_exact_q;

endmodule
`default_nettype wire

// File: tb/tb_fxp2fp_norm_pack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fxp2fp_norm_pack
// Purpose  : Self-checking bench for fxp2fp_norm_pack. Accepted beats push a
//            reference result to a queue; output transfers push the observed
//            word to a second queue; scenario tasks pop and compare both.
//            Expected rounding follows FP_ROUND_RNE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxp2fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [31:0] in_mag;
  logic [5:0]  in_lzd;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_exact;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  always #5 clk = ~clk;

  fxp2fp_norm_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .in_lzd    (in_lzd),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_exact (out_exact)
  );

  function automatic logic [5:0] lzd_of(logic [31:0] m);
    for (int i = 31; i >= 0; i--) if (m[i]) return 6'(31 - i);
    return 6'd32;
  endfunction

  // Reference: {exact, float32} from sign and magnitude (value = m / 2^31).
  function automatic logic [32:0] model(logic s, logic [31:0] m);
    logic [31:0] n;
    logic [7:0]  e;
    logic [23:0] mt;
    logic [7:0]  rem;
    int          p;
    if (m == 32'd0) return {1'b1, 32'h0000_0000};
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    n   = m << (31 - p);
    e   = 8'(96 + p);
    mt  = {1'b0, n[30:8]};
    rem = n[7:0];
`ifdef FP_ROUND_RNE_EN
    if (rem > 8'h80 || (rem == 8'h80 && mt[0])) mt = mt + 24'd1;
`endif
    if (mt[23]) begin
      e  = e + 8'd1;
      mt = 24'd0;
    end
    return {(rem == 8'd0), s, e, mt[22:0]};
  endfunction

  // Scoreboard monitor: sample mid-cycle, where handshakes are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_mag));
      if (out_valid && out_ready) got_q.push_back({out_exact, out_data});
    end
  end

  task automatic set_in(input logic s, input logic [31:0] m);
    in_sign = s;
    in_mag  = m;
    in_zero = (m == 32'd0);
    in_lzd  = lzd_of(m);
  endtask

  // Offer one beat and hold it until accepted; called at posedge+1.
  task automatic send(input logic s, input logic [31:0] m, output bit ok);
    set_in(s, m);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Let the pipe empty until every accepted beat has been observed.
  task automatic wait_drain(output bit ok);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ok = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    for (int c = 0; c < 50; c++) begin
      if (got_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    total++;
    if (out_exact !== 1'b0) begin bad++; $display("FAIL reset_out_exact got=%b want=0", out_exact); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic;
    bit ok;
    logic [32:0] e, g;
    out_ready = 1'b1;
    set_in(1'b1, 32'h8000_0000);
    in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_latency_early got=%b want=0", out_valid); end
    @(negedge clk);
    total++;
    if ({out_valid, out_exact, out_data} !== {1'b1, 1'b1, 32'hBF80_0000})
      begin bad++; $display("FAIL basic_minus_one got=%b/%b/%h want=1/1/bf800000", out_valid, out_exact, out_data); end
    @(posedge clk); #1;
    send(1'b0, 32'h4000_0000, ok);
    if (ok) send(1'b1, 32'h0000_0000, ok);
    if (ok) send(1'b0, 32'h0000_0001, ok);
    if (ok) wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL basic_sb got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_rounding;
    bit ok;
    logic [32:0] e, g;
    logic [31:0] mags [4];
    logic [31:0] want [4];
    mags = '{32'h7FFF_FFFF, 32'h4000_0040, 32'h4000_00C0, 32'h4000_0000};
`ifdef FP_ROUND_RNE_EN
    want = '{32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0002, 32'h3F00_0000};
`else
    want = '{32'h3F7F_FFFF, 32'h3F00_0000, 32'h3F00_0001, 32'h3F00_0000};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, mags[i], ok);
      wait_drain(ok);
      total++;
      if (!ok || got_q.size() == 0) begin
        bad++; $display("FAIL round_timeout idx=%0d got=0 want=1", i);
      end else begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (g[31:0] !== want[i]) begin bad++; $display("FAIL round_const idx=%0d got=%h want=%h", i, g[31:0], want[i]); end
        total++;
        if (g[32] !== (i == 3)) begin bad++; $display("FAIL round_exact idx=%0d got=%b want=%b", i, g[32], (i == 3)); end
        total++;
        if (g !== e) begin bad++; $display("FAIL round_sb idx=%0d got=%h want=%h", i, g, e); end
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int k, acc, base, cyc;
    logic [31:0] held;
    logic [32:0] e, g;
    logic [31:0] bm [5];
    bm = '{32'h8000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0FFF_FFFF, 32'h4000_00C0};
    base = got_q.size();
    out_ready = 1'b0;
    k = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      set_in(k[0], bm[k]);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin acc++; k++; end
      @(posedge clk); #1;
    end
    total++;
    if (acc != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc); end
    @(negedge clk);
    held = out_data;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    repeat (2) @(negedge clk);
    total++;
    if (out_data !== held || out_valid !== 1'b1)
      begin bad++; $display("FAIL bp_stable got=%h/%b want=%h/1", out_data, out_valid, held); end
    e = model(1'b0, bm[0]);
    total++;
    if (out_data !== e[31:0]) begin bad++; $display("FAIL bp_head got=%h want=%h", out_data, e[31:0]); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (k < 5) begin set_in(k[0], bm[k]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk); #1;
      if (in_valid && in_ready) k++;
      if (got_q.size() >= base + 5) begin cyc = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (cyc != 5) begin bad++; $display("FAIL bp_drain_cycles got=%0d want=5", cyc); end
    wait_drain(ok);
    total++;
    if (got_q.size() != base + 5 || exp_q.size() != base + 5)
      begin bad++; $display("FAIL bp_count got=%0d/%0d want=%0d", got_q.size(), exp_q.size(), base + 5); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL bp_sb got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int k;
    logic [32:0] e, g;
    logic [31:0] rm [30];
    logic        rs [30];
    for (int i = 0; i < 30; i++) begin
      rm[i] = ($urandom >> 1) >> $urandom_range(0, 31);
      if (i % 7 == 0) rm[i] = 32'h0;
      if (i % 11 == 0) rm[i] = 32'h8000_0000;
      rs[i] = 1'($urandom_range(0, 1));
    end
    k = 0;
    for (int c = 0; c < 400 && k < 30; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      set_in(rs[k], rm[k]);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    wait_drain(ok);
    total++;
    if (!ok || k != 30 || got_q.size() != 30)
      begin bad++; $display("FAIL b2b_count got=%0d/%0d want=30", k, got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL b2b_sb got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    out_ready = 1'b0;
    send(1'b1, 32'h8000_0000, ok);
    if (ok) send(1'b0, 32'h2000_0000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_load got=0 want=1"); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_exact, out_data} !== 34'h0)
      begin bad++; $display("FAIL rstmid_async got=%b/%b/%h want=0/0/00000000", out_valid, out_exact, out_data); end
    exp_q.delete();
    got_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (got_q.size() != 0 || out_valid !== 1'b0)
      begin bad++; $display("FAIL rstmid_stale got=%0d want=0", got_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    test_reset;
    @(posedge clk); #1;
    test_basic;
    test_rounding;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
